// File: rtl/fp32_mul_dispatch.sv
// Operand feeder and result collector for the 32-bit FP multiplier.
// Tagged operand pairs are queued in a small FIFO and issued one at a time.
// The result comes back with a tag and exception status. A watchdog aborts
// an operation whose multiplier never reports done.
module fp32_mul_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_a_i,
  input  logic [31:0]      in_b_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             mul_start_o,
  output logic [31:0]      mul_a_o,
  output logic [31:0]      mul_b_o,
  input  logic             mul_done_i,
  input  logic [31:0]      mul_product_i,
  input  logic             mul_nan_i,
  input  logic             mul_inf_i,
  input  logic             mul_ovf_i,
  input  logic             mul_unf_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_product_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic [4:0]       out_status_o,
  output logic             busy_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [WD_W-1:0]  WD_ZERO   = {WD_W{1'b0}};
  localparam logic [WD_W-1:0]  WD_ONE    = WD_W'(1);
  localparam logic [WD_W-1:0]  TIMEOUT_C = WD_W'(TIMEOUT);
  localparam logic [31:0]      QNAN_C    = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  // Operand FIFO storage (no reset needed: validity is tracked by count_r)
  logic [31:0]      fifo_a_r   [DEPTH];
  logic [31:0]      fifo_b_r   [DEPTH];
  logic [TAG_W-1:0] fifo_tag_r [DEPTH];

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;

  state_t           state_r;
  state_t           state_next_s;

  logic [31:0]      op_a_r;
  logic [31:0]      op_b_r;
  logic [TAG_W-1:0] op_tag_r;
  logic [WD_W-1:0]  wd_r;
  logic [WD_W-1:0]  wd_inc_s;
  logic [3:0]       exc_r;
  logic             timeout_r;
  logic [31:0]      product_r;

  logic             start_r;
  logic             out_valid_r;
  logic             in_ready_r;
  logic             busy_r;

  logic             push_s;
  logic             pop_s;

  // The head is popped on the edge that enters ISSUE, so operands are ready for the start cycle
  assign push_s   = in_valid_i && in_ready_r;
  assign pop_s    = (state_r == ST_IDLE) && (count_r != CNT_ZERO);
  assign wd_inc_s = wd_r + WD_ONE;

  // Next-state decode for the dispatch FSM and the FIFO occupancy
  always_comb begin
    state_next_s = state_r;
    count_next_s = count_r;
    case (state_r)
      ST_IDLE: begin
        if (count_r != CNT_ZERO) begin
          state_next_s = ST_ISSUE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE:   state_next_s = ST_WAIT;
      ST_WAIT: begin
        if (mul_done_i) begin
          state_next_s = ST_CAPTURE;
        end else if (wd_inc_s == TIMEOUT_C) begin
          state_next_s = ST_HOLD;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_CAPTURE: state_next_s = ST_HOLD;
      ST_HOLD: begin
        if (out_ready_i) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      default:    state_next_s = ST_IDLE;
    endcase
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Write accepted operand pairs into the FIFO
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_a_r[wr_ptr_r]   <= in_a_i;
      fifo_b_r[wr_ptr_r]   <= in_b_i;
      fifo_tag_r[wr_ptr_r] <= in_tag_i;
    end
  end

  // State, pointers, operand hold, watchdog, result capture and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= CNT_ZERO;
      op_a_r      <= 32'h0;
      op_b_r      <= 32'h0;
      op_tag_r    <= {TAG_W{1'b0}};
      wd_r        <= WD_ZERO;
      exc_r       <= 4'b0000;
      timeout_r   <= 1'b0;
      product_r   <= 32'h0;
      start_r     <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r <= state_next_s;
      count_r <= count_next_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
        op_a_r   <= fifo_a_r[rd_ptr_r];
        op_b_r   <= fifo_b_r[rd_ptr_r];
        op_tag_r <= fifo_tag_r[rd_ptr_r];
      end
      case (state_r)
        ST_ISSUE: wd_r <= WD_ZERO;
        ST_WAIT: begin
          wd_r <= wd_inc_s;
          if (mul_done_i) begin
            exc_r     <= {mul_nan_i, mul_inf_i, mul_ovf_i, mul_unf_i};
            timeout_r <= 1'b0;
          end else if (wd_inc_s == TIMEOUT_C) begin
            exc_r     <= 4'b0000;
            timeout_r <= 1'b1;
            product_r <= QNAN_C;
          end
        end
        ST_CAPTURE: product_r <= mul_product_i;
        default:    wd_r <= wd_r;
      endcase
      start_r     <= (state_next_s == ST_ISSUE);
      out_valid_r <= (state_next_s == ST_HOLD);
      in_ready_r  <= (count_next_s != DEPTH_C);
      busy_r      <= (state_next_s != ST_IDLE) || (count_next_s != CNT_ZERO);
    end
  end

  assign in_ready_o    = in_ready_r;
  assign mul_start_o   = start_r;
  assign mul_a_o       = op_a_r;
  assign mul_b_o       = op_b_r;
  assign out_valid_o   = out_valid_r;
  assign out_product_o = product_r;
  assign out_tag_o     = op_tag_r;
  assign out_status_o  = {timeout_r, exc_r};
  assign busy_o        = busy_r;

endmodule

// File: tb/tb_fp32_mul_dispatch.sv
// Self-checking bench for fp32_mul_dispatch: a stub multiplier answers each
// start after an operand-dependent delay, and a scoreboard of expected
// results is built from the accepted operands in acceptance order.
module tb_fp32_mul_dispatch;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      in_a_i;
  logic [31:0]      in_b_i;
  logic [TAG_W-1:0] in_tag_i;
  logic             mul_start_o;
  logic [31:0]      mul_a_o;
  logic [31:0]      mul_b_o;
  logic             mul_done_i;
  logic [31:0]      mul_product_i;
  logic             mul_nan_i, mul_inf_i, mul_ovf_i, mul_unf_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [31:0]      out_product_o;
  logic [TAG_W-1:0] out_tag_o;
  logic [4:0]       out_status_o;
  logic             busy_o;

  always #5 clk = ~clk;

  fp32_mul_dispatch #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_a_i(in_a_i), .in_b_i(in_b_i), .in_tag_i(in_tag_i),
    .mul_start_o(mul_start_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_done_i(mul_done_i), .mul_product_i(mul_product_i),
    .mul_nan_i(mul_nan_i), .mul_inf_i(mul_inf_i),
    .mul_ovf_i(mul_ovf_i), .mul_unf_i(mul_unf_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_product_o(out_product_o), .out_tag_o(out_tag_o),
    .out_status_o(out_status_o), .busy_o(busy_o)
  );

  typedef struct {
    logic [31:0]      prod;
    logic [TAG_W-1:0] tag;
    logic [4:0]       status;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   stab_viol = 0;

  // ---------------- stub multiplier behaviour ----------------
  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
  endfunction

  // Cycles from the start cycle to the done cycle; 0xBAD0xxxx answers very late
  function automatic int mdl_delay(input logic [31:0] a, input logic [31:0] b);
    if (a[31:16] == 16'hBAD0) return 11;
    return 2 + ((int'(a[7:0]) + int'(b[7:0])) % 8);
  endfunction

  function automatic logic [31:0] mdl_prod(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    if (is_nan(a) || is_nan(b)) return 32'h0000_0000;
    return a ^ b ^ 32'h1234_5678;
  endfunction

  // {nan, inf, ovf, unf}
  function automatic logic [3:0] mdl_flags(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x;
    if (is_nan(a) || is_nan(b)) return 4'b1000;
    x = a ^ b;
    return {1'b0, x[2:0]};
  endfunction

  // Reference: done within TIMEOUT wait cycles gives the product, otherwise a quiet-NaN abort
  function automatic exp_t ref_result(input logic [31:0] a, input logic [31:0] b,
                                      input logic [TAG_W-1:0] tag);
    exp_t e;
    e.tag = tag;
    if (mdl_delay(a, b) > TIMEOUT) begin
      e.prod   = 32'h7FC0_0000;
      e.status = 5'b10000;
    end else begin
      e.prod   = mdl_prod(a, b);
      e.status = {1'b0, mdl_flags(a, b)};
    end
    return e;
  endfunction

  int          m_cnt = 0;
  int          m_trk = 0;
  logic        m_pend = 1'b0;
  logic [31:0] m_a, m_b;

  // Stub multiplier: done after mdl_delay cycles, product one cycle later, operand watch while busy
  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 0; m_trk <= 0; m_pend <= 1'b0;
      mul_done_i <= 1'b0;
      {mul_nan_i, mul_inf_i, mul_ovf_i, mul_unf_i} <= 4'b0000;
      mul_product_i <= 32'hFFFF_FFFF;
    end else begin
      mul_done_i <= 1'b0;
      {mul_nan_i, mul_inf_i, mul_ovf_i, mul_unf_i} <= 4'b0000;
      m_pend <= 1'b0;
      mul_product_i <= m_pend ? mdl_prod(m_a, m_b) : 32'hFFFF_FFFF;
      if (m_trk > 0) begin
        if (mul_a_o !== m_a || mul_b_o !== m_b) stab_viol <= stab_viol + 1;
        m_trk <= m_trk - 1;
      end
      if (mul_start_o) begin
        m_a   <= mul_a_o;
        m_b   <= mul_b_o;
        m_cnt <= mdl_delay(mul_a_o, mul_b_o) - 1;
        m_trk <= ((mdl_delay(mul_a_o, mul_b_o) > TIMEOUT) ? TIMEOUT
                                                          : mdl_delay(mul_a_o, mul_b_o)) + 1;
      end else if (m_cnt == 1) begin
        mul_done_i <= 1'b1;
        {mul_nan_i, mul_inf_i, mul_ovf_i, mul_unf_i} <= mdl_flags(m_a, m_b);
        m_pend <= 1'b1;
        m_cnt  <= 0;
      end else if (m_cnt > 1) begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
    int w = 0;
    in_valid_i = 1'b1; in_a_i = a; in_b_i = b; in_tag_i = tag;
    while (in_ready_o !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("push_ready", 32'(in_ready_o), 32'h1);
    sb_q.push_back(ref_result(a, b, tag));
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  task automatic get_result(input string name);
    int   w = 0;
    exp_t e;
    while (out_valid_o !== 1'b1 && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk({name, "_valid"}, 32'(out_valid_o), 32'h1);
    if (sb_q.size() == 0) begin
      chk({name, "_unexpected"}, 32'(out_valid_o), 32'h0);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_product"}, out_product_o, e.prod);
      chk({name, "_tag"}, 32'(out_tag_o), 32'(e.tag));
      chk({name, "_status"}, 32'(out_status_o), 32'(e.status));
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
    chk({name, "_drop"}, 32'(out_valid_o), 32'h0);
  endtask

  function automatic logic [31:0] rand_a();
    logic [31:0] a;
    a = $urandom();
    if (a[31:16] == 16'hBAD0) a[31] = ~a[31];
    return a;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int          k;
    int          n;
    int          seen;
    logic [TAG_W-1:0] t;

    rst = 1'b1; in_valid_i = 1'b0; in_a_i = 32'h0; in_b_i = 32'h0;
    in_tag_i = '0; out_ready_i = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_in_ready", 32'(in_ready_o), 32'h1);
    chk("rst_out_valid", 32'(out_valid_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_start", 32'(mul_start_o), 32'h0);
    chk("rst_mul_a", mul_a_o, 32'h0);
    chk("rst_product", out_product_o, 32'h0);
    chk("rst_status", 32'(out_status_o), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Single op with cycle-exact latency: handshake edge 0, start in cycle 2, valid in cycle 6
    in_valid_i = 1'b1; in_a_i = 32'h4000_0000; in_b_i = 32'h4040_0000; in_tag_i = 4'd5;
    sb_q.push_back(ref_result(32'h4000_0000, 32'h4040_0000, 4'd5));
    @(negedge clk);
    in_valid_i = 1'b0;
    chk("single_busy", 32'(busy_o), 32'h1);
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) @(negedge clk);
      chk($sformatf("single_start_c%0d", c), 32'(mul_start_o), 32'(c == 2));
      chk($sformatf("single_valid_c%0d", c), 32'(out_valid_o), 32'(c == 6));
    end
    chk("single_product_const", out_product_o, 32'h40C0_0000);
    get_result("single");
    @(negedge clk);
    chk("single_idle_busy", 32'(busy_o), 32'h0);

    // NaN operand: status reports nan only, product passed through
    push_op(32'h7FC0_0001, 32'h3F80_0000, 4'd1);
    get_result("nan");

    // FIFO full: one op in flight plus DEPTH queued, further offers stall
    for (int i = 0; i < 5; i++) push_op(rand_a(), $urandom(), TAG_W'(i));
    chk("full_in_ready", 32'(in_ready_o), 32'h0);
    in_valid_i = 1'b1; in_a_i = 32'h3F80_0000; in_b_i = 32'h3F80_0000; in_tag_i = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("full_stall", 32'(in_ready_o), 32'h0);
    end
    in_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) get_result($sformatf("full_%0d", i));
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid_o === 1'b1) seen = 1;
    end
    chk("full_no_extra", 32'(seen), 32'h0);

    // Watchdog boundary: done in the last wait cycle completes, one later aborts
    push_op(32'h3F80_0006, 32'h3F80_0000, 4'd6);
    get_result("done_last_wait");
    push_op(32'h3F80_0007, 32'h3F80_0000, 4'd7);
    get_result("done_too_late");

    // Timeout with a very late done: result TIMEOUT+1 cycles after start, late done ignored
    push_op(32'hBAD0_0000, 32'h3F80_0000, 4'd9);
    k = 0;
    while (mul_start_o !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("to_start_seen", 32'(mul_start_o), 32'h1);
    k = 0;
    while (out_valid_o !== 1'b1 && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("to_latency", 32'(k), 32'(TIMEOUT + 1));
    get_result("timeout");
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid_o === 1'b1 || busy_o === 1'b1) seen = 1;
    end
    chk("to_late_done_ignored", 32'(seen), 32'h0);
    push_op(32'h4000_0000, 32'h4040_0000, 4'd10);
    get_result("after_timeout");

    // Randomised bursts: queue while the consumer stalls, then drain in order
    t = 4'd0;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        push_op(rand_a(), $urandom(), t);
        t = t + 4'd1;
      end
      for (int i = 0; i < n; i++) get_result($sformatf("rand_r%0d_%0d", r, i));
    end
    chk("operand_stability", 32'(stab_viol), 32'h0);

    // Reset in the middle of WAIT discards the operation
    push_op(32'hBAD0_0001, 32'h3F80_0000, 4'd12);
    k = 0;
    while (mul_start_o !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    chk("midrst_in_ready", 32'(in_ready_o), 32'h1);
    chk("midrst_out_valid", 32'(out_valid_o), 32'h0);
    chk("midrst_busy", 32'(busy_o), 32'h0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid_o === 1'b1 || mul_start_o === 1'b1) seen = 1;
    end
    chk("midrst_no_result", 32'(seen), 32'h0);
    push_op(32'h4000_0000, 32'h4040_0000, 4'd3);
    get_result("after_midrst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
